fcall_rr_scheduler: RTL and testbench

- Shares one generated function core among NREQ requesters, granting in round-robin order.
- The core uses the standard generated-function handshake: start / idle / valid / retval, with an active-low reset.
- The block arbitrates, issues the start, waits for valid and returns the result to the winning requester.
- A watchdog aborts and resets a hung core. Sits between client FSMs and a single HLS core instance.

---
 rtl/fcall_rr_scheduler.sv | 144 ++++++++++++++
 tb/tb_fcall_rr_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcall_rr_scheduler.sv
// Round-robin front end for a single HLS-generated function core: arbitrates
// NREQ clients, issues start, returns the result and aborts a hung core.
module fcall_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic             __clk,
    input  logic             __reset,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  ack,
    output logic [NREQ-1:0]  done,
    output logic [WIDTH-1:0] result,
    output logic             error,
    output logic             busy,
    output logic             core_resetn,
    output logic             core_start,
    input  logic             core_idle,
    input  logic             core_valid,
    input  logic [WIDTH-1:0] core_retval,
    output logic [2:0]       state_dbg
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    // Handshake: req is a level held by the client until its ack pulse; ack and
    // core_start pulse together in ISSUE; done (with error on abort) pulses once
    // per accepted call and result is meaningful only while done is high.
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, RECOVER} state_t;

    state_t           state, state_d;
    logic [IW-1:0]    owner, owner_d;
    logic [IW-1:0]    ptr, ptr_d;
    logic [IW-1:0]    pick, idx;
    logic             found;
    logic [CW-1:0]    cnt, cnt_d;
    logic             rec2, rec2_d;
    logic [NREQ-1:0]  ack_d, done_d;
    logic [WIDTH-1:0] result_d;
    logic             error_d, busy_d, start_d;

    // First requester strictly after the last served one, wrapping around.
    always_comb begin
        pick  = ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d  = state;
        owner_d  = owner;
        ptr_d    = ptr;
        cnt_d    = cnt;
        rec2_d   = 1'b0;
        ack_d    = '0;
        done_d   = '0;
        result_d = result;
        error_d  = 1'b0;
        start_d  = 1'b0;
        case (state)
            IDLE: begin
                if (found && core_idle) begin
                    owner_d = pick;
                    ack_d   = ONE << pick;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt + CW'(1);
                // A valid in the last allowed cycle still counts as success.
                if (core_valid) begin
                    result_d = core_retval;
                    done_d   = ONE << owner;
                    state_d  = DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_d = RECOVER;
                end
            end
            DONE: begin
                ptr_d   = owner;
                state_d = IDLE;
            end
            RECOVER: begin
                if (!rec2) begin
                    rec2_d   = 1'b1;
                    done_d   = ONE << owner;
                    error_d  = 1'b1;
                    result_d = '0;
                end else begin
                    ptr_d   = owner;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge __clk) begin
        if (__reset) begin
            state      <= IDLE;
            owner      <= '0;
            ptr        <= IW'(NREQ - 1);
            cnt        <= '0;
            rec2       <= 1'b0;
            ack        <= '0;
            done       <= '0;
            result     <= '0;
            error      <= 1'b0;
            busy       <= 1'b0;
            core_start <= 1'b0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            ptr        <= ptr_d;
            cnt        <= cnt_d;
            rec2       <= rec2_d;
            ack        <= ack_d;
            done       <= done_d;
            result     <= result_d;
            error      <= error_d;
            busy       <= busy_d;
            core_start <= start_d;
        end
    end

    // The core is held in reset with the block and for both abort cycles.
    assign core_resetn = !(__reset || state == RECOVER);
    assign state_dbg   = state;

endmodule

// File: tb/tb_fcall_rr_scheduler.sv
// Bench for fcall_rr_scheduler: directed scenarios plus random traffic, every
// cycle compared with a call-level timing model of the scheduler.
module tb_fcall_rr_scheduler;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 20;
    localparam int CM_HOLD = 0;
    localparam int CM_ONCE = 1;
    localparam int CM_RAND = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req, ack, done;
    logic [WIDTH-1:0] result, core_retval;
    logic             error, busy, core_resetn, core_start, core_idle, core_valid;
    logic [2:0]       state_dbg;

    always #5 clk = ~clk;

    fcall_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .__clk(clk), .__reset(rst), .req(req), .ack(ack), .done(done),
        .result(result), .error(error), .busy(busy), .core_resetn(core_resetn),
        .core_start(core_start), .core_idle(core_idle), .core_valid(core_valid),
        .core_retval(core_retval), .state_dbg(state_dbg)
    );

    int checks = 0;
    int failures = 0;
    logic [NREQ-1:0] exp_q[$];
    logic [NREQ-1:0] one = 1;

    // stimulus configuration
    int cm = CM_HOLD;
    logic [NREQ-1:0] req_cfg = '0;
    bit rst_cfg = 1'b1, fb_cfg = 1'b0, hang = 1'b0, rand_lat = 1'b0;
    int s_lat = 2, retmode = 0, s_cnt = 0;
    logic [WIDTH-1:0] s_val = 0;

    // previous-cycle inputs as sampled by the DUT
    bit rst_p = 1'b1, idle_p = 1'b1, valid_p = 1'b0, start_p = 1'b0, resetn_p = 1'b0;
    logic [NREQ-1:0] req_p = '0;
    logic [WIDTH-1:0] retval_p = '0;

    // call-level model
    int cyc = 0;
    bit m_active = 1'b0, m_err = 1'b0, m_recover = 1'b0;
    int m_g = 0, m_owner = 0, m_ptr = NREQ - 1, m_idle_from = 0, m_done_at = -1;
    logic [WIDTH-1:0] m_res = '0;

    // observation counters used by directed steps
    int last_ack = 0, last_done = 0, acks_seen = 0, dones_seen = 0, rn_low = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int rr(input int ptr, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++)
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return 0;
    endfunction

    task automatic model_check();
        logic [NREQ-1:0] e_ack, e_done;
        if (rst_p) begin
            m_active = 1'b0; m_recover = 1'b0; m_ptr = NREQ - 1; m_idle_from = cyc;
            chk("rst_ack", ack, 0);
            chk("rst_start", core_start, 0);
            chk("rst_done", done, 0);
            chk("rst_error", error, 0);
            chk("rst_busy", busy, 0);
            chk("rst_result", result, 0);
            chk("rst_core_resetn", core_resetn, 0);
            return;
        end
        m_recover = 1'b0;
        if (!m_active) begin
            if (cyc - 1 >= m_idle_from && req_p != 0 && idle_p) begin
                m_owner = rr(m_ptr, req_p); m_g = cyc; m_active = 1'b1; m_done_at = -1;
            end
        end else if (m_done_at < 0) begin
            if (valid_p && cyc - 1 >= m_g + 1 && cyc - 1 <= m_g + TIMEOUT) begin
                m_done_at = cyc; m_err = 1'b0; m_res = retval_p;
            end else if (cyc == m_g + TIMEOUT + 1) begin
                m_recover = 1'b1;
            end else if (cyc == m_g + TIMEOUT + 2) begin
                m_recover = 1'b1; m_done_at = cyc; m_err = 1'b1; m_res = '0;
            end
        end
        e_ack  = (m_active && cyc == m_g) ? (one << m_owner) : '0;
        e_done = (m_active && cyc == m_done_at) ? (one << m_owner) : '0;
        chk("ack", ack, e_ack);
        chk("core_start", core_start, |e_ack);
        chk("done", done, e_done);
        chk("error", error, (|e_done) && m_err);
        chk("busy", busy, m_active);
        chk("core_resetn", core_resetn, !m_recover);
        if (|e_done) begin
            chk("result", result, m_res);
            m_active = 1'b0; m_ptr = m_owner; m_idle_from = cyc + 1;
        end
    endtask

    task automatic drive();
        bit fb;
        rst = (cm == CM_RAND) ? ($urandom_range(0, 399) == 0) : rst_cfg;
        core_valid = 1'b0;
        if (!resetn_p) s_cnt = 0;
        else if (start_p) s_cnt = hang ? 1000000 : (rand_lat ? int'($urandom_range(1, 22)) : s_lat);
        else if (s_cnt > 0) begin
            s_cnt--;
            if (s_cnt == 0) begin
                core_valid = 1'b1;
                core_retval = (retmode == 0) ? s_val : (retmode == 1) ? WIDTH'(m_owner) : $urandom();
            end
        end
        fb = (cm == CM_RAND) ? ($urandom_range(0, 9) == 0) : fb_cfg;
        core_idle = !(fb || s_cnt != 0);
        if (cm == CM_HOLD) req = req_cfg;
        else if (cm == CM_ONCE) begin
            req_cfg = req_cfg & ~ack;
            req = req_cfg;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ack[i]) req[i] = ($urandom_range(0, 1) == 1);
                else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_check();
        if (|ack) begin last_ack = cyc; acks_seen++; end
        if (|done) begin last_done = cyc; dones_seen++; end
        if (!core_resetn && !rst_p) rn_low++;
        drive();
        rst_p = rst; req_p = req; idle_p = core_idle; valid_p = core_valid;
        retval_p = core_retval; start_p = core_start;
        #1;
        resetn_p = core_resetn;
    endtask

    task automatic do_reset();
        cm = CM_HOLD; req_cfg = '0; fb_cfg = 1'b0; hang = 1'b0; rand_lat = 1'b0;
        rst_cfg = 1'b1;
        repeat (2) tick();
        rst_cfg = 1'b0;
        tick();
        acks_seen = 0; dones_seen = 0; rn_low = 0;
    endtask

    task automatic wait_ack(input string tag, input int limit);
        int n = 0;
        int a0 = acks_seen;
        while (acks_seen == a0 && n < limit) begin tick(); n++; end
        chk(tag, acks_seen - a0, 1);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        int d0 = dones_seen;
        while (dones_seen == d0 && n < limit) begin tick(); n++; end
        chk(tag, dones_seen - d0, 1);
    endtask

    initial begin
        int prev;
        rst = 1'b1; req = '0; core_idle = 1'b1; core_valid = 1'b0; core_retval = '0;

        // single call to a summing core returning 1+2
        do_reset();
        s_lat = 2; retmode = 0; s_val = 32'd3;
        cm = CM_ONCE; req_cfg = 4'b0001;
        tick();
        tick();
        chk("a_ack0", ack, 4'b0001);
        repeat (8) tick();
        chk("a_done_once", dones_seen, 1);

        // all four requesting, fixed latency 5, result = client index
        do_reset();
        s_lat = 5; retmode = 1;
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        cm = CM_HOLD; req_cfg = 4'b1111;
        prev = -1;
        for (int n = 0; n < 80 && exp_q.size() != 0; n++) begin
            tick();
            if (|ack) begin
                chk("b_order", ack, exp_q.pop_front());
                if (prev >= 0) chk("b_spacing", cyc - prev, 9);
                prev = cyc;
            end
        end
        chk("b_all_acks", exp_q.size(), 0);
        req_cfg = '0;
        repeat (10) tick();
        chk("b_dones", dones_seen, 5);

        // hung core: abort after TIMEOUT, then a normal call
        do_reset();
        hang = 1'b1; cm = CM_ONCE; req_cfg = 4'b0100;
        wait_ack("c_ack", 10);
        wait_done("c_done", 40);
        chk("c_latency", last_done - last_ack, TIMEOUT + 2);
        chk("c_resetn_low", rn_low, 2);
        hang = 1'b0; s_lat = 3; retmode = 2; req_cfg = 4'b0010;
        wait_done("c_next_done", 20);
        chk("c_next_no_abort", rn_low, 2);

        // requests ignored while the core reports not idle
        do_reset();
        fb_cfg = 1'b1; s_lat = 2; cm = CM_ONCE; req_cfg = 4'b0100;
        repeat (10) tick();
        chk("d_no_ack", acks_seen, 0);
        fb_cfg = 1'b0;
        tick();
        tick();
        chk("d_ack2", ack, 4'b0100);
        repeat (6) tick();

        // reset in the middle of WAIT abandons the call
        do_reset();
        s_lat = 10; cm = CM_ONCE; req_cfg = 4'b0001;
        wait_ack("e_ack", 10);
        repeat (3) tick();
        rst_cfg = 1'b1;
        tick();
        tick();
        chk("e_busy", busy, 0);
        chk("e_resetn", core_resetn, 0);
        rst_cfg = 1'b0;
        repeat (15) tick();
        chk("e_no_done", dones_seen, 0);

        // valid in the very cycle the timeout would fire
        do_reset();
        s_lat = TIMEOUT - 1; retmode = 0; s_val = 32'hA5A5_0F0F;
        cm = CM_ONCE; req_cfg = 4'b1000;
        wait_ack("f_ack", 10);
        wait_done("f_done", 40);
        chk("f_latency", last_done - last_ack, TIMEOUT + 1);
        chk("f_resetn_high", rn_low, 0);
        repeat (3) tick();

        // random traffic, latencies around the timeout, idle glitches, resets
        do_reset();
        rand_lat = 1'b1; retmode = 2; cm = CM_RAND;
        repeat (3000) tick();
        cm = CM_HOLD; req_cfg = '0; rst_cfg = 1'b0;
        repeat (30) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
